multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
// - Multi-cycle FSM that sequences the RV32 datapath: fetch, decode, execute, memory, writeback.
// - Drives the strobes for IR latch, ALU, data memory, register-file write and PC update.
// - Decode fields come from the combinational control unit, which decodes the latched IR.
// - Handshakes with instruction and data memory; raises a trap on illegal opcode or memory timeout.
// PARAMETERS
// - TIMEOUT_CYCLES  16  max cycles a req may wait for ack before trap (1..255)
// - RESET_PC_SEL    0   pc_sel value driven while idle/reset
// PORTS
// - clk          in   1   rising-edge clock
// - rst_n        in   1   asynchronous assert, active-low reset
// - imem_req     out  1   instruction fetch request, held until imem_ack
// - imem_ack     in   1   fetch data valid this cycle
// - ir_we        out  1   latch instruction register (1-cycle pulse)
// - dec_illegal  in   1   control unit: unsupported opcode/funct3
// - dec_mem_rd   in   1   instruction is a load
// - dec_mem_wr   in   1   instruction is a store
// - dec_wb       in   1   instruction writes rd
// - dec_branch   in   1   instruction is a branch/jump
// - br_taken     in   1   branch condition true (valid in EXECUTE/WB)
// - alu_en       out  1   ALU operand/result register enable
// - dmem_req     out  1   data request, held until dmem_ack
// - dmem_we      out  1   1 = store, 0 = load; valid while dmem_req
// - dmem_ack     in   1   data access complete
// - rf_we        out  1   register-file write enable (1-cycle pulse)
// - pc_we        out  1   PC update strobe (1-cycle pulse)
// - pc_sel       out  1   0 = PC+4, 1 = branch target; valid with pc_we
// - trap         out  1   sticky trap flag
// - trap_cause   out  2   00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
// - trap_clr     in   1   clear trap, resume at FETCH
// - state_o      out  3   current FSM state (debug)
// - instret      out  32  retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state = FETCH; all strobes, trap and trap_cause = 0; instret = 0.
// - FETCH: imem_req = 1.
//   - On imem_ack: ir_we = 1 in the same cycle, then go to DECODE.
// - DECODE (1 cycle):
//   - dec_illegal: go to TRAP with cause 01.
//   - Otherwise: go to EXECUTE.
// - EXECUTE (1 cycle): alu_en = 1.
//   - If dec_mem_rd or dec_mem_wr: go to MEM.
//   - Otherwise: go to WB.
// - MEM: dmem_req = 1, dmem_we = dec_mem_wr.
//   - On ack with a load: go to WB.
//   - On ack with a store: pc_we = 1, pc_sel = 0, retire, go to FETCH.
// - WB (1 cycle): rf_we = dec_wb; pc_we = 1; pc_sel = dec_branch & br_taken; retire; go to FETCH.
// - Timing with zero-wait acks:
//   - ALU instruction: 4 cycles (FETCH..WB).
//   - Load: 5 cycles.
//   - Store: 4 cycles.
// - Timeout:
//   - An 8-bit wait counter clears on entry to FETCH/MEM and increments each cycle without ack.
//   - When count == TIMEOUT_CYCLES-1 with no ack: drop req, go to TRAP, cause 10 or 11.
//   - An ack in that same final cycle wins; no trap.
// - TRAP: all strobes 0; trap = 1; hold state.
//   - trap_clr: trap/cause cleared, go to FETCH next cycle; PC is not advanced.
// - trap_clr outside TRAP is ignored.
// - The ack inputs are ignored outside their requesting state; a stray ack has no effect.
// - req never drops before its ack, except on timeout or reset.
// - Reset mid-transaction: outputs go to 0 immediately (async); the memory side must abandon the access.
// - A single instruction never asserts rf_we and dmem_we together.
// CONFIGURATION
// - SEQ_PERF_CNT_EN defined: instret counts +1 per retire (WB exit or store ack).
//   - Wraps 0xFFFFFFFF -> 0; not incremented on trap.
// - SEQ_PERF_CNT_EN undefined: instret tied to 32'h0; no counter flops.
// STRUCTURE
// - riscv_pkg: seq_state_t {FETCH, DECODE, EXECUTE, MEM, WB, TRAP}; trap-cause constants; TIMEOUT width.
// - Sub-module seq_timeout_timer: clear/enable/expired wait counter, parameterised by TIMEOUT_CYCLES.
// TESTING
// - ALU op, ack in the 1st fetch cycle:
//   - ir_we at cycle 0, alu_en at 2, rf_we=1 and pc_we=1 at 3 with pc_sel=0; instret 0->1.
// - Load, dmem_ack after 3 wait cycles:
//   - dmem_req high 4 cycles with dmem_we=0, then rf_we=1 in the next cycle; 8 cycles total.
// - Taken branch, dec_wb=0, br_taken=1:
//   - WB: pc_we=1, pc_sel=1, rf_we=0.
// - Illegal op, dec_illegal=1:
//   - TRAP, trap_cause=01, no pc_we; trap_clr -> FETCH next cycle, imem_req=1.
// - imem_ack withheld:
//   - After 16 cycles: imem_req=0, trap=1, cause=10.
//   - Repeat with ack in cycle 15: no trap.
// - Reset mid-MEM (rst_n low during dmem_req):
//   - All outputs 0 asynchronously; after release, state_o=FETCH and instret=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the multi-cycle RV32 sequencer:
// FSM state encoding, trap-cause codes and the wait-counter width.
package riscv_pkg;

   localparam int unsigned TIMEOUT_W = 8;

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM     = 3'd3,
      WB      = 3'd4,
      TRAP    = 3'd5
   } seq_state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
   localparam logic [1:0] CAUSE_IMEM_TO  = 2'b10;
   localparam logic [1:0] CAUSE_DMEM_TO  = 2'b11;

   // States in which a memory request is outstanding and the timeout runs.
   function automatic logic is_wait_state(input seq_state_t s);
      return (s == FETCH) || (s == MEM);
   endfunction

endpackage

// File: rtl/seq_timeout_timer.sv
// Wait counter for memory handshakes: cleared by clr_i, counts while en_i,
// flags expired_o in the last permitted wait cycle (count == TIMEOUT_CYCLES-1).
module seq_timeout_timer
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_W-1:0] cnt_q;
   logic [TIMEOUT_W-1:0] cnt_d;

   // Next count: clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {TIMEOUT_W{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {TIMEOUT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 control sequencer (FETCH/DECODE/EXECUTE/MEM/WB/TRAP).
// Define SEQ_PERF_CNT_EN to build the retired-instruction counter on instret.
module multicycle_sequencer
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic        RESET_PC_SEL   = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        ir_we,
   input  logic        dec_illegal,
   input  logic        dec_mem_rd,
   input  logic        dec_mem_wr,
   input  logic        dec_wb,
   input  logic        dec_branch,
   input  logic        br_taken,
   output logic        alu_en,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        trap,
   output logic [1:0]  trap_cause,
   input  logic        trap_clr,
   output logic [2:0]  state_o,
   output logic [31:0] instret
);

   seq_state_t state_q, state_d;
   logic [1:0] cause_q, cause_d;

   logic waiting_s, ack_s, expired_s, retire_s;
   logic imem_req_s, ir_we_s, alu_en_s, dmem_req_s, dmem_we_s;
   logic rf_we_s, pc_we_s, pc_sel_s;

   // Handshake qualification: only the ack belonging to the current request counts.
   always_comb begin
      waiting_s = is_wait_state(state_q);
      if (state_q == FETCH) begin
         ack_s = imem_ack;
      end else if (state_q == MEM) begin
         ack_s = dmem_ack;
      end else begin
         ack_s = 1'b0;
      end
   end

   seq_timeout_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (!waiting_s || ack_s),
      .en_i      (waiting_s && !ack_s),
      .expired_o (expired_s)
   );

   // Next-state and strobe decode; an ack in the expiring cycle beats the timeout.
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      imem_req_s = 1'b0;
      ir_we_s    = 1'b0;
      alu_en_s   = 1'b0;
      dmem_req_s = 1'b0;
      dmem_we_s  = 1'b0;
      rf_we_s    = 1'b0;
      pc_we_s    = 1'b0;
      pc_sel_s   = RESET_PC_SEL;
      retire_s   = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req_s = 1'b1;
            if (imem_ack) begin
               ir_we_s = 1'b1;
               state_d = DECODE;
            end else if (expired_s) begin
               state_d = TRAP;
               cause_d = CAUSE_IMEM_TO;
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            if (dec_illegal) begin
               state_d = TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = EXECUTE;
            end
         end
         EXECUTE: begin
            alu_en_s = 1'b1;
            if (dec_mem_rd || dec_mem_wr) begin
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            dmem_req_s = 1'b1;
            dmem_we_s  = dec_mem_wr;
            if (dmem_ack) begin
               if (dec_mem_wr) begin
                  pc_we_s  = 1'b1;
                  pc_sel_s = 1'b0;
                  retire_s = 1'b1;
                  state_d  = FETCH;
               end else begin
                  state_d  = WB;
               end
            end else if (expired_s) begin
               state_d = TRAP;
               cause_d = CAUSE_DMEM_TO;
            end else begin
               state_d = MEM;
            end
         end
         WB: begin
            rf_we_s  = dec_wb;
            pc_we_s  = 1'b1;
            pc_sel_s = dec_branch & br_taken;
            retire_s = 1'b1;
            state_d  = FETCH;
         end
         TRAP: begin
            if (trap_clr) begin
               state_d = FETCH;
               cause_d = CAUSE_NONE;
            end else begin
               state_d = TRAP;
            end
         end
         default: begin
            state_d = FETCH;
            cause_d = CAUSE_NONE;
         end
      endcase
   end

   // State and trap-cause registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   // Strobes are gated by rst_n so an in-flight access is dropped the instant reset asserts.
   assign imem_req   = imem_req_s & rst_n;
   assign ir_we      = ir_we_s    & rst_n;
   assign alu_en     = alu_en_s   & rst_n;
   assign dmem_req   = dmem_req_s & rst_n;
   assign dmem_we    = dmem_we_s  & rst_n;
   assign rf_we      = rf_we_s    & rst_n;
   assign pc_we      = pc_we_s    & rst_n;
   assign pc_sel     = rst_n ? pc_sel_s : RESET_PC_SEL;
   assign trap       = (state_q == TRAP);
   assign trap_cause = cause_q;
   assign state_o    = state_q;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] instret_q, instret_d;

   // Retire counter; wraps naturally at 2^32.
   always_comb begin
      if (retire_s) begin
         instret_d = instret_q + 32'd1;
      end else begin
         instret_d = instret_q;
      end
   end

   // Retire counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_q <= 32'd0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;
`else
   logic unused_retire_s;
   assign unused_retire_s = retire_s;
   assign instret         = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; outputs are checked
// 1 ns after each falling edge, inputs are driven on the falling edge.
module tb_multicycle_sequencer;

   localparam logic [2:0] S_FETCH = 3'd0;
   localparam logic [2:0] S_DEC   = 3'd1;
   localparam logic [2:0] S_EX    = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;
   localparam logic [2:0] S_TRAP  = 3'd5;
`ifdef SEQ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk, rst_n;
   logic imem_req, imem_ack, ir_we;
   logic dec_illegal, dec_mem_rd, dec_mem_wr, dec_wb, dec_branch, br_taken;
   logic alu_en, dmem_req, dmem_we, dmem_ack, rf_we, pc_we, pc_sel, trap, trap_clr;
   logic [1:0]  trap_cause;
   logic [2:0]  state_o;
   logic [31:0] instret;

   int errors = 0;
   int checks = 0;

   multicycle_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
      .dec_illegal(dec_illegal), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
      .dec_wb(dec_wb), .dec_branch(dec_branch), .br_taken(br_taken),
      .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .trap(trap), .trap_cause(trap_cause), .trap_clr(trap_clr),
      .state_o(state_o), .instret(instret)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Strobe order: imem_req ir_we alu_en dmem_req dmem_we rf_we pc_we pc_sel
   function automatic logic [13:0] outs();
      return {imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
              trap, trap_cause, state_o};
   endfunction

   function automatic logic [13:0] e(input logic [7:0] s, input logic t,
                                     input logic [1:0] c, input logic [2:0] st);
      return {s, t, c, st};
   endfunction

   function automatic logic [31:0] ir(input logic [31:0] n);
      return PERF ? n : 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [13:0] exp);
      #1;
      chk(tag, {18'd0, outs()}, {18'd0, exp});
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; trap_clr = 1'b0;
      dec_illegal = 1'b0; dec_mem_rd = 1'b0; dec_mem_wr = 1'b0;
      dec_wb = 1'b0; dec_branch = 1'b0; br_taken = 1'b0;
      #2;
      chk("reset_outs", {18'd0, outs()}, 32'd0);
      chk("reset_instret", instret, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU op, ack in first fetch cycle
      imem_ack = 1'b1; dec_wb = 1'b1;
      cyc("alu_fetch",  e(8'b11000000, 1'b0, 2'b00, S_FETCH));
      imem_ack = 1'b0;
      cyc("alu_decode", e(8'b00000000, 1'b0, 2'b00, S_DEC));
      cyc("alu_exec",   e(8'b00100000, 1'b0, 2'b00, S_EX));
      cyc("alu_wb",     e(8'b00000110, 1'b0, 2'b00, S_WB));
      chk("instret_alu", instret, ir(32'd1));

      // Load, dmem_ack after 3 wait cycles; stray acks in DECODE
      imem_ack = 1'b1; dec_mem_rd = 1'b1;
      cyc("ld_fetch", e(8'b11000000, 1'b0, 2'b00, S_FETCH));
      dmem_ack = 1'b1;
      cyc("ld_decode_stray_ack", e(8'b00000000, 1'b0, 2'b00, S_DEC));
      imem_ack = 1'b0; dmem_ack = 1'b0;
      cyc("ld_exec", e(8'b00100000, 1'b0, 2'b00, S_EX));
      for (int i = 0; i < 3; i++) cyc($sformatf("ld_mem_wait%0d", i), e(8'b00010000, 1'b0, 2'b00, S_MEM));
      dmem_ack = 1'b1;
      cyc("ld_mem_ack", e(8'b00010000, 1'b0, 2'b00, S_MEM));
      dmem_ack = 1'b0;
      cyc("ld_wb", e(8'b00000110, 1'b0, 2'b00, S_WB));
      chk("instret_ld", instret, ir(32'd2));

      // Store, zero-wait
      imem_ack = 1'b1; dec_mem_rd = 1'b0; dec_mem_wr = 1'b1; dec_wb = 1'b0;
      cyc("st_fetch", e(8'b11000000, 1'b0, 2'b00, S_FETCH));
      imem_ack = 1'b0;
      cyc("st_decode", e(8'b00000000, 1'b0, 2'b00, S_DEC));
      cyc("st_exec",   e(8'b00100000, 1'b0, 2'b00, S_EX));
      dmem_ack = 1'b1;
      cyc("st_mem_ack", e(8'b00011010, 1'b0, 2'b00, S_MEM));
      dmem_ack = 1'b0;
      chk("instret_st", instret, ir(32'd3));

      // Taken branch
      imem_ack = 1'b1; dec_mem_wr = 1'b0; dec_branch = 1'b1; br_taken = 1'b1;
      cyc("br_fetch", e(8'b11000000, 1'b0, 2'b00, S_FETCH));
      imem_ack = 1'b0;
      cyc("br_decode", e(8'b00000000, 1'b0, 2'b00, S_DEC));
      cyc("br_exec",   e(8'b00100000, 1'b0, 2'b00, S_EX));
      cyc("br_wb",     e(8'b00000011, 1'b0, 2'b00, S_WB));
      chk("instret_br", instret, ir(32'd4));

      // Illegal opcode -> TRAP, then clear
      imem_ack = 1'b1; dec_branch = 1'b0; br_taken = 1'b0; dec_illegal = 1'b1;
      cyc("ill_fetch", e(8'b11000000, 1'b0, 2'b00, S_FETCH));
      imem_ack = 1'b0;
      cyc("ill_decode", e(8'b00000000, 1'b0, 2'b00, S_DEC));
      cyc("ill_trap",   e(8'b00000000, 1'b1, 2'b01, S_TRAP));
      imem_ack = 1'b1;
      cyc("ill_trap_hold", e(8'b00000000, 1'b1, 2'b01, S_TRAP));
      imem_ack = 1'b0; trap_clr = 1'b1;
      cyc("ill_trap_clr", e(8'b00000000, 1'b1, 2'b01, S_TRAP));
      trap_clr = 1'b0; dec_illegal = 1'b0;
      chk("instret_ill", instret, ir(32'd4));

      // imem_ack withheld: 16 wait cycles then trap cause 10
      for (int i = 0; i < 16; i++) cyc($sformatf("imem_wait%0d", i), e(8'b10000000, 1'b0, 2'b00, S_FETCH));
      trap_clr = 1'b1;
      cyc("imem_to_trap", e(8'b00000000, 1'b1, 2'b10, S_TRAP));
      trap_clr = 1'b0;

      // ack in cycle 15 wins over the timeout
      for (int i = 0; i < 15; i++) cyc($sformatf("imem_wait_b%0d", i), e(8'b10000000, 1'b0, 2'b00, S_FETCH));
      imem_ack = 1'b1; dec_wb = 1'b1;
      cyc("imem_last_ack", e(8'b11000000, 1'b0, 2'b00, S_FETCH));
      imem_ack = 1'b0;
      cyc("imem_last_decode", e(8'b00000000, 1'b0, 2'b00, S_DEC));
      cyc("imem_last_exec",   e(8'b00100000, 1'b0, 2'b00, S_EX));
      cyc("imem_last_wb",     e(8'b00000110, 1'b0, 2'b00, S_WB));
      chk("instret_late_ack", instret, ir(32'd5));

      // dmem_ack withheld on a load: trap cause 11
      imem_ack = 1'b1; dec_mem_rd = 1'b1;
      cyc("dto_fetch", e(8'b11000000, 1'b0, 2'b00, S_FETCH));
      imem_ack = 1'b0;
      cyc("dto_decode", e(8'b00000000, 1'b0, 2'b00, S_DEC));
      cyc("dto_exec",   e(8'b00100000, 1'b0, 2'b00, S_EX));
      for (int i = 0; i < 16; i++) cyc($sformatf("dmem_wait%0d", i), e(8'b00010000, 1'b0, 2'b00, S_MEM));
      trap_clr = 1'b1;
      cyc("dmem_to_trap", e(8'b00000000, 1'b1, 2'b11, S_TRAP));
      trap_clr = 1'b0;
      chk("instret_dto", instret, ir(32'd5));

      // Reset asserted mid-MEM on a store
      imem_ack = 1'b1; dec_mem_rd = 1'b0; dec_mem_wr = 1'b1; dec_wb = 1'b0;
      cyc("rst_fetch", e(8'b11000000, 1'b0, 2'b00, S_FETCH));
      imem_ack = 1'b0;
      cyc("rst_decode", e(8'b00000000, 1'b0, 2'b00, S_DEC));
      cyc("rst_exec",   e(8'b00100000, 1'b0, 2'b00, S_EX));
      #1;
      chk("rst_mem_pre", {18'd0, outs()}, {18'd0, e(8'b00011000, 1'b0, 2'b00, S_MEM)});
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_outs", {18'd0, outs()}, 32'd0);
      chk("rst_async_instret", instret, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; dec_mem_wr = 1'b0;
      chk("rst_release_instret", instret, 32'd0);
      cyc("rst_release", e(8'b10000000, 1'b0, 2'b00, S_FETCH));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
